gps_code_gen_axil: RTL and testbench

- AXI4-Lite register-mapped GPS spreading-code generator.
- On software request it produces a 13-chip C/A code word, a 128-chip P code block, and a 128-bit L code (P code XOR a programmable 128-bit key).
- Chip timing comes from two GPS strobe inputs generated at the CEP top level.
- Sits on the CEP peripheral bus as a 32-bit AXI4-Lite slave.

---
 rtl/gps_code_gen_axil.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_gps_code_gen_axil.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_code_gen_axil.sv
// AXI4-Lite slave that generates GPS C/A, P and keyed L spreading codes on request.
// Chip timing comes from the synchronised rising edges of the two GPS chip-rate inputs.
module gps_code_gen_axil #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            gps_clk_fast,
    input  logic            gps_clk_slow,
    input  logic [AW-1:0]   s_awaddr,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [DW-1:0]   s_wdata,
    input  logic [DW/8-1:0] s_wstrb,
    input  logic            s_wvalid,
    output logic            s_wready,
    output logic [1:0]      s_bresp,
    output logic            s_bvalid,
    input  logic            s_bready,
    input  logic [AW-1:0]   s_araddr,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [DW-1:0]   s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rvalid,
    input  logic            s_rready
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    localparam logic [3:0] CA_CHIPS = 4'd13;
    localparam logic [7:0] P_CHIPS  = 8'd128;

    state_e       state_q, state_d;

    logic [2:0]   fast_sync_q, slow_sync_q;
    logic         fast_stb, slow_stb;

    logic         rdy_en_q;
    logic         aw_got_q, w_got_q, bvalid_q;
    logic [5:0]   awidx_q;
    logic [31:0]  wdata_q;
    logic [3:0]   wstrb_q;
    logic         rvalid_q;
    logic [31:0]  rdata_q;

    logic         gen_last_q;
    logic [4:0]   prn_q;
    logic [127:0] key_q, key_d;

    logic [10:1]  g1_q, g1_d, g2_q, g2_d;
    logic [12:1]  x1a_q, x1a_d, x2a_q, x2a_d;
    logic [12:0]  ca_q, ca_d;
    logic [127:0] p_q, p_d, l_q, l_d;
    logic [3:0]   ca_cnt_q, ca_cnt_d;
    logic [7:0]   p_cnt_q, p_cnt_d;
    logic         done_q, done_d;

    logic         wr_fire, wr_gen, wr_prn, wr_key, start;
    logic         ca_done, p_done, ca_chip, p_chip;
    logic [7:0]   taps;
    logic [5:0]   rd_idx;
    logic [31:0]  rd_word;
    logic         unused_addr;

    // G2 phase-select tap pairs {ta, tb} for PRN 1..32 (register value 0..31).
    function automatic logic [7:0] ca_taps(input logic [4:0] prn);
        case (prn)
            5'd0:  ca_taps = {4'd2, 4'd6};
            5'd1:  ca_taps = {4'd3, 4'd7};
            5'd2:  ca_taps = {4'd4, 4'd8};
            5'd3:  ca_taps = {4'd5, 4'd9};
            5'd4:  ca_taps = {4'd1, 4'd9};
            5'd5:  ca_taps = {4'd2, 4'd10};
            5'd6:  ca_taps = {4'd1, 4'd8};
            5'd7:  ca_taps = {4'd2, 4'd9};
            5'd8:  ca_taps = {4'd3, 4'd10};
            5'd9:  ca_taps = {4'd2, 4'd3};
            5'd10: ca_taps = {4'd3, 4'd4};
            5'd11: ca_taps = {4'd5, 4'd6};
            5'd12: ca_taps = {4'd6, 4'd7};
            5'd13: ca_taps = {4'd7, 4'd8};
            5'd14: ca_taps = {4'd8, 4'd9};
            5'd15: ca_taps = {4'd9, 4'd10};
            5'd16: ca_taps = {4'd1, 4'd4};
            5'd17: ca_taps = {4'd2, 4'd5};
            5'd18: ca_taps = {4'd3, 4'd6};
            5'd19: ca_taps = {4'd4, 4'd7};
            5'd20: ca_taps = {4'd5, 4'd8};
            5'd21: ca_taps = {4'd6, 4'd9};
            5'd22: ca_taps = {4'd1, 4'd3};
            5'd23: ca_taps = {4'd4, 4'd6};
            5'd24: ca_taps = {4'd5, 4'd7};
            5'd25: ca_taps = {4'd6, 4'd8};
            5'd26: ca_taps = {4'd7, 4'd9};
            5'd27: ca_taps = {4'd8, 4'd10};
            5'd28: ca_taps = {4'd1, 4'd6};
            5'd29: ca_taps = {4'd2, 4'd7};
            5'd30: ca_taps = {4'd3, 4'd8};
            5'd31: ca_taps = {4'd4, 4'd9};
        endcase
    endfunction

    // Word 0 of a 128-bit register is its most significant 32 bits.
    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] sel);
        case (sel)
            2'd0: word_of = v[127:96];
            2'd1: word_of = v[95:64];
            2'd2: word_of = v[63:32];
            2'd3: word_of = v[31:0];
        endcase
    endfunction

    assign fast_stb = fast_sync_q[1] & ~fast_sync_q[2];
    assign slow_stb = slow_sync_q[1] & ~slow_sync_q[2];

    // rdy_en_q keeps every ready low through reset and the first cycle after it.
    assign s_awready = rdy_en_q & ~bvalid_q & ~aw_got_q;
    assign s_wready  = rdy_en_q & ~bvalid_q & ~w_got_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = 2'b00;
    assign s_arready = rdy_en_q & ~rvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = 2'b00;

    assign unused_addr = ^{s_awaddr[AW-1:8], s_awaddr[1:0], s_araddr[AW-1:8], s_araddr[1:0]};

    assign wr_fire = aw_got_q & w_got_q;
    assign wr_gen  = wr_fire && (awidx_q == 6'd0);
    assign wr_prn  = wr_fire && (awidx_q == 6'd2);
    assign wr_key  = wr_fire && (awidx_q[5:2] == 4'd4);
    assign start   = wr_gen && wdata_q[0] && !gen_last_q && (state_q == ST_IDLE);

    assign ca_done = (ca_cnt_q == CA_CHIPS);
    assign p_done  = (p_cnt_q == P_CHIPS);
    assign taps    = ca_taps(prn_q);
    assign ca_chip = g1_q[10] ^ g2_q[taps[7:4]] ^ g2_q[taps[3:0]];
    assign p_chip  = x1a_q[12] ^ x2a_q[12];

    always_comb begin
        key_d = key_q;
        if (wr_key) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    key_d[int'({~awidx_q[1:0], 5'd0}) + b*8 +: 8] = wdata_q[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        g1_d     = g1_q;
        g2_d     = g2_q;
        x1a_d    = x1a_q;
        x2a_d    = x2a_q;
        ca_d     = ca_q;
        p_d      = p_q;
        l_d      = l_q;
        ca_cnt_d = ca_cnt_q;
        p_cnt_d  = p_cnt_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_BUSY;
                    done_d   = 1'b0;
                    ca_d     = '0;
                    p_d      = '0;
                    ca_cnt_d = '0;
                    p_cnt_d  = '0;
                end
            end
            ST_BUSY: begin
                if (ca_done && p_done) begin
                    l_d     = p_q ^ key_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Both generators may advance in the same cycle.
                    if (slow_stb && !ca_done) begin
                        ca_d     = {ca_q[11:0], ca_chip};
                        g1_d     = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
                        g2_d     = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
                        ca_cnt_d = ca_cnt_q + 4'd1;
                    end
                    if (fast_stb && !p_done) begin
                        p_d     = {p_q[126:0], p_chip};
                        x1a_d   = {x1a_q[11:1], x1a_q[6] ^ x1a_q[8] ^ x1a_q[11] ^ x1a_q[12]};
                        x2a_d   = {x2a_q[11:1], x2a_q[1] ^ x2a_q[3] ^ x2a_q[4] ^ x2a_q[5] ^ x2a_q[7]
                                              ^ x2a_q[8] ^ x2a_q[9] ^ x2a_q[10] ^ x2a_q[11] ^ x2a_q[12]};
                        p_cnt_d = p_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_idx = s_araddr[7:2];

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            6'd1: rd_word = {31'd0, done_q};
            6'd2: rd_word = {27'd0, prn_q};
            6'd4: rd_word = {19'd0, ca_q};
            default: begin
                case (rd_idx[5:2])
                    4'd2: rd_word = word_of(p_q, rd_idx[1:0]);
                    4'd3: rd_word = word_of(l_q, rd_idx[1:0]);
                    4'd4: rd_word = word_of(key_q, rd_idx[1:0]);
                    default: rd_word = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fast_sync_q <= '0;
            slow_sync_q <= '0;
            rdy_en_q    <= 1'b0;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            bvalid_q    <= 1'b0;
            awidx_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            gen_last_q  <= 1'b0;
            prn_q       <= '0;
        end else begin
            fast_sync_q <= {fast_sync_q[1:0], gps_clk_fast};
            slow_sync_q <= {slow_sync_q[1:0], gps_clk_slow};
            rdy_en_q    <= 1'b1;
            if (s_awvalid && s_awready) begin
                aw_got_q <= 1'b1;
                awidx_q  <= s_awaddr[7:2];
            end
            if (s_wvalid && s_wready) begin
                w_got_q <= 1'b1;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            if (wr_fire) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_bready) begin
                bvalid_q <= 1'b0;
            end
            if (wr_gen) gen_last_q <= wdata_q[0];
            if (wr_prn && wstrb_q[0]) prn_q <= wdata_q[4:0];
            if (s_arvalid && s_arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (rvalid_q && s_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            g1_q     <= '1;
            g2_q     <= '1;
            x1a_q    <= 12'b001001001000;
            x2a_q    <= 12'b100100100101;
            ca_q     <= '0;
            p_q      <= '0;
            l_q      <= '0;
            ca_cnt_q <= '0;
            p_cnt_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            g1_q     <= g1_d;
            g2_q     <= g2_d;
            x1a_q    <= x1a_d;
            x2a_q    <= x2a_d;
            ca_q     <= ca_d;
            p_q      <= p_d;
            l_q      <= l_d;
            ca_cnt_q <= ca_cnt_d;
            p_cnt_q  <= p_cnt_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_gps_code_gen_axil.sv
// Directed bench for gps_code_gen_axil: register access, code generation, handshakes and reset abort.
module tb_gps_code_gen_axil;

    localparam logic [31:0] A_GEN  = 32'h00;
    localparam logic [31:0] A_DONE = 32'h04;
    localparam logic [31:0] A_PRN  = 32'h08;
    localparam logic [31:0] A_CA   = 32'h10;
    localparam logic [31:0] A_P    = 32'h20;
    localparam logic [31:0] A_L    = 32'h30;
    localparam logic [31:0] A_KEY  = 32'h40;
    localparam logic [9:0]  PRN1_FIRST10 = 10'b1100100000;

    logic        clk = 1'b0, rst_ni = 1'b0, gps_clk_fast = 1'b0, gps_clk_slow = 1'b0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

    logic [10:1]  mg1, mg2;
    logic [12:1]  mx1, mx2;
    logic [12:0]  mca;
    logic [127:0] mp;

    always #5 clk = ~clk;
    always #20 gps_clk_fast = ~gps_clk_fast;
    always #200 gps_clk_slow = ~gps_clk_slow;

    gps_code_gen_axil #(.AW(32), .DW(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .gps_clk_fast(gps_clk_fast), .gps_clk_slow(gps_clk_slow),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mg1 = '1;
        mg2 = '1;
        mx1 = 12'b001001001000;
        mx2 = 12'b100100100101;
    endtask

    // Reference C/A and P generators; state carries over between calls like the hardware.
    task automatic model_gen(input int ta, input int tb);
        logic f;
        mca = '0;
        mp  = '0;
        for (int i = 0; i < 13; i++) begin
            mca = {mca[11:0], mg1[10] ^ mg2[ta] ^ mg2[tb]};
            f   = mg1[3] ^ mg1[10];
            mg1 = {mg1[9:1], f};
            f   = mg2[2] ^ mg2[3] ^ mg2[6] ^ mg2[8] ^ mg2[9] ^ mg2[10];
            mg2 = {mg2[9:1], f};
        end
        for (int i = 0; i < 128; i++) begin
            mp  = {mp[126:0], mx1[12] ^ mx2[12]};
            f   = mx1[6] ^ mx1[8] ^ mx1[11] ^ mx1[12];
            mx1 = {mx1[11:1], f};
            f   = mx2[1] ^ mx2[3] ^ mx2[4] ^ mx2[5] ^ mx2[7] ^ mx2[8] ^ mx2[9] ^ mx2[10] ^ mx2[11] ^ mx2[12];
            mx2 = {mx2[11:1], f};
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int bhold,
                             output logic [1:0] resp, output int bhigh);
        bit aw_done, w_done, aw_hs, w_hs, got;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; bhigh = 0; got = 0; resp = 2'bxx;
        @(posedge clk); #1;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (cyc == aw_dly && !aw_done) begin s_awvalid = 1'b1; s_awaddr = addr; end
            if (cyc == w_dly && !w_done) begin s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb; end
            @(negedge clk);
            aw_hs = s_awvalid & s_awready;
            w_hs  = s_wvalid & s_wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
            if (w_hs) begin w_done = 1; s_wvalid = 1'b0; end
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (s_bvalid) got = 1;
            else begin @(posedge clk); #1; end
        end
        if (got) begin
            resp = s_bresp;
            for (int i = 0; i < bhold; i++) begin
                @(negedge clk);
                if (s_bvalid) bhigh++;
            end
            s_bready = 1'b1;
            @(posedge clk); #1;
            s_bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit hs, got;
        int n;
        hs = 0; got = 0; n = 0; data = 'x; resp = 2'bxx;
        @(posedge clk); #1;
        s_arvalid = 1'b1;
        s_araddr  = addr;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = s_arready;
            @(posedge clk); #1;
            n++;
        end
        s_arvalid = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (s_rvalid) got = 1;
            else begin @(posedge clk); #1; end
        end
        if (got) begin
            data = s_rdata;
            resp = s_rresp;
            s_rready = 1'b1;
            @(posedge clk); #1;
            s_rready = 1'b0;
        end
    endtask

    task automatic read128(input logic [31:0] base, output logic [127:0] v);
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 4; i++) begin
            axi_read(base + 32'(i*4), d, r);
            v[127 - i*32 -: 32] = d;
        end
    endtask

    task automatic poll_done(output bit ok);
        logic [31:0] d;
        logic [1:0]  r;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            axi_read(A_DONE, d, r);
            if (d[0] === 1'b1) ok = 1;
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  d;
        logic [1:0]   r;
        logic [127:0] v, key;
        int           bh, zeros;
        bit           ok;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_awready", s_awready, 0);
        check("rst_wready", s_wready, 0);
        check("rst_arready", s_arready, 0);
        check("rst_bvalid", s_bvalid, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_rdata", s_rdata, 0);
        rst_ni = 1'b1;

        for (int a = 0; a < 'h54; a += 4) begin
            axi_read(32'(a), d, r);
            check($sformatf("rst_read_%02h", a), d, 0);
        end
        check("rresp_okay", r, 2'b00);

        axi_write(A_GEN, 32'd1, 4'hF, 0, 0, 0, r, bh);
        check("bresp_okay", r, 2'b00);
        axi_write(A_GEN, 32'd0, 4'hF, 0, 0, 0, r, bh);
        model_gen(2, 6);
        poll_done(ok);
        check("gen1_done", ok, 1);
        axi_read(A_CA, d, r);
        check("gen1_ca_first10", d[12:3], PRN1_FIRST10);
        check("gen1_ca", d, {19'd0, mca});
        read128(A_P, v);
        check("gen1_p", v, mp);
        read128(A_L, v);
        check("gen1_l_eq_p", v, mp);

        for (int k = 0; k < 4; k++) axi_write(A_KEY + 32'(k*4), 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, bh);
        axi_read(A_KEY, d, r);
        check("key_word0", d, 32'hFFFF_FFFF);
        axi_write(A_GEN, 32'd1, 4'hF, 0, 0, 0, r, bh);
        axi_write(A_GEN, 32'd0, 4'hF, 0, 0, 0, r, bh);
        model_gen(2, 6);
        poll_done(ok);
        check("gen2_done", ok, 1);
        read128(A_P, v);
        check("gen2_p_chips129_256", v, mp);
        read128(A_L, v);
        check("gen2_l_inv_p", v, ~mp);
        axi_read(A_CA, d, r);
        check("gen2_ca", d, {19'd0, mca});

        axi_write(A_GEN, 32'd1, 4'hF, 0, 0, 0, r, bh);
        axi_read(A_DONE, d, r);
        check("busy_done_low", d, 0);
        axi_write(A_GEN, 32'd1, 4'hF, 0, 0, 0, r, bh);
        model_gen(2, 6);
        poll_done(ok);
        check("gen3_done", ok, 1);
        zeros = 0;
        repeat (150) begin
            axi_read(A_DONE, d, r);
            if (d[0] !== 1'b1) zeros++;
        end
        check("gen3_no_restart", zeros, 0);
        read128(A_P, v);
        check("gen3_p", v, mp);
        axi_read(A_CA, d, r);
        check("gen3_ca", d, {19'd0, mca});
        axi_write(A_GEN, 32'd0, 4'hF, 0, 0, 0, r, bh);

        axi_write(A_PRN, 32'd1, 4'hF, 0, 3, 5, r, bh);
        check("split_bresp", r, 2'b00);
        check("bvalid_held", bh, 5);
        @(posedge clk); #1;
        s_arvalid = 1'b1;
        s_araddr  = A_PRN;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = s_arready;
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rdata_hold", {s_rvalid, s_rdata}, {1'b1, 32'd1});
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;

        axi_write(A_KEY + 32'hC, 32'h0000_0000, 4'b0011, 2, 0, 0, r, bh);
        axi_read(A_KEY + 32'hC, d, r);
        check("key_wstrb", d, 32'hFFFF_0000);
        key = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hFFFF_0000};
        axi_write(A_GEN, 32'd1, 4'hF, 0, 0, 0, r, bh);
        axi_write(A_GEN, 32'd0, 4'hF, 0, 0, 0, r, bh);
        model_gen(3, 7);
        poll_done(ok);
        check("prn2_done", ok, 1);
        axi_read(A_CA, d, r);
        check("prn2_ca", d, {19'd0, mca});
        read128(A_L, v);
        check("prn2_l", v, mp ^ key);

        axi_write(A_GEN, 32'd1, 4'hF, 0, 0, 0, r, bh);
        repeat (200) @(posedge clk);
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_bvalid", s_bvalid, 0);
        check("abort_arready", s_arready, 0);
        rst_ni = 1'b1;
        axi_read(A_DONE, d, r);
        check("abort_done", d, 0);
        axi_read(A_CA, d, r);
        check("abort_ca", d, 0);
        axi_read(A_PRN, d, r);
        check("abort_prn", d, 0);
        axi_read(A_KEY, d, r);
        check("abort_key", d, 0);
        model_reset();
        axi_write(A_GEN, 32'd1, 4'hF, 0, 0, 0, r, bh);
        axi_write(A_GEN, 32'd0, 4'hF, 0, 0, 0, r, bh);
        model_gen(2, 6);
        poll_done(ok);
        check("post_rst_done", ok, 1);
        axi_read(A_CA, d, r);
        check("post_rst_ca_first10", d[12:3], PRN1_FIRST10);
        read128(A_P, v);
        check("post_rst_p", v, mp);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
